// File: rtl/rr_arbiter_8_pkg.sv
// rr_arbiter_8_pkg
// Shared definitions for the 8-way round-robin arbiter: requester count,
// index width, hold-counter width and the two-state FSM encoding.
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_8_dec3to8_onehot.sv
// dec3to8_onehot
// Decodes a 3-bit index into an 8-bit one-hot vector; all-zero when disabled.
// Ports:
//   idx_i    : index to decode
//   en_i     : enable; when low the output is 8'h00
//   onehot_o : one-hot result, bit idx_i set when enabled
module dec3to8_onehot
    import rr_arbiter_8_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] onehot_o
);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bit
        assign onehot_o[gi] = en_i && (idx_i == IDX_W'(gi));
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8
// Round-robin arbiter sharing one resource among eight requesters. In IDLE it
// picks the first requester at or after the rotating pointer, then holds the
// grant until the owner signals done, drops its request, or the hold limit
// expires (the latter raises a one-cycle timeout pulse).
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   req       : request vector, bit i = requester i
//   done      : owner finished (only looked at while granting)
//   gnt       : one-hot grant, zero when no grant is active
//   gnt_idx   : index of the current (or most recent) owner
//   gnt_valid : a grant is active
//   timeout   : pulse in the first IDLE cycle after a forced revocation
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] pick_d;
    logic             any_req;
    logic             owner_req;
    logic             hold_hit;
    logic             release_now;

    // Rotate so that ptr lands at bit 0, find the lowest set bit, then add the
    // pointer back; the 3-bit sum wraps modulo 8 naturally.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] p
    );
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        dbl = {r, r};
        rot = dbl[p +: N_REQ];
        off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = IDX_W'(j);
        end
        return p + off;
    endfunction

    always_comb begin
        pick_d      = rr_pick(req, ptr_q);
        any_req     = |req;
        owner_req   = req[idx_q];
        hold_hit    = (cnt_q == HOLD_LAST);
        release_now = done || !owner_req || hold_hit;
        cnt_d       = (cnt_q < HOLD_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timeout_q <= 1'b0;
                    if (any_req) begin
                        idx_q   <= pick_d;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        // Pointer moves only on a new grant, just past the winner.
                        ptr_q   <= pick_d + IDX_W'(1);
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    cnt_q <= cnt_d;
                    if (release_now) begin
                        valid_q   <= 1'b0;
                        // Forced only if neither done nor a dropped request explains it.
                        timeout_q <= !done && owner_req;
                        state_q   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

    dec3to8_onehot u_dec (
        .idx_i    (idx_q),
        .en_i     (valid_q),
        .onehot_o (gnt)
    );

endmodule
